// File: rtl/aes_pkg.sv
// Shared AES byte-substitution tables and lookup helpers for the S-box pipeline.
package aes_pkg;

  localparam int AES_BYTE_W = 8;

  localparam logic [AES_BYTE_W-1:0] SBOX_FWD [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [AES_BYTE_W-1:0] SBOX_INV [0:255] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [AES_BYTE_W-1:0] sbox_fwd(input logic [AES_BYTE_W-1:0] b);
    return SBOX_FWD[b];
  endfunction

  function automatic logic [AES_BYTE_W-1:0] sbox_inv(input logic [AES_BYTE_W-1:0] b);
    return SBOX_INV[b];
  endfunction

endpackage

// File: rtl/aes_sbox_lane.sv
// Single-byte combinational AES substitution; the inverse table is only built
// when INV_EN is set.
module aes_sbox_lane
  import aes_pkg::*;
#(
  parameter int INV_EN = 1
) (
  input  logic [AES_BYTE_W-1:0] a,
  input  logic                  inv,
  output logic [AES_BYTE_W-1:0] c
);

  generate
    if (INV_EN != 0) begin : g_inv
      // Per-byte forward/inverse selection.
      always_comb begin
        if (inv) begin
          c = sbox_inv(a);
        end else begin
          c = sbox_fwd(a);
        end
      end
    end else begin : g_fwd
      logic unused_inv_s;
      assign unused_inv_s = inv;

      // Forward-only lookup; the mode input has no effect in this build.
      always_comb begin
        c = sbox_fwd(a);
      end
    end
  endgenerate

endmodule

// File: rtl/aes_sbox_pipe.sv
// Multi-lane pipelined AES S-box with valid/ready handshake, bubble-collapsing
// stages, synchronous flush and a registered occupancy count.
module aes_sbox_pipe
  import aes_pkg::*;
#(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2,
  parameter int INV_EN      = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_inv,
  input  logic [AES_BYTE_W*LANES-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_inv,
  output logic [AES_BYTE_W*LANES-1:0] out_data,
  output logic [2:0]                  occupancy
);

  localparam int DW   = AES_BYTE_W * LANES;
  localparam int LAST = PIPE_STAGES - 1;

  logic [PIPE_STAGES-1:0]         v_q, v_d;
  logic [PIPE_STAGES-1:0]         m_q, m_d;
  logic [PIPE_STAGES-1:0][DW-1:0] d_q, d_d;
  logic [2:0]                     occ_q, occ_d;

  logic [PIPE_STAGES-1:0] ready_s;
  logic [DW-1:0]          sub_s;
  logic                   mode_s;
  logic                   full_s;
  logic                   accept_s;
  logic                   emit_s;

  assign mode_s = (INV_EN != 0) ? in_inv : 1'b0;

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      aes_sbox_lane #(
        .INV_EN(INV_EN)
      ) u_lane (
        .a  (in_data[AES_BYTE_W*i +: AES_BYTE_W]),
        .inv(mode_s),
        .c  (sub_s[AES_BYTE_W*i +: AES_BYTE_W])
      );
    end
  endgenerate

  // Stage s may load unless it and every stage downstream of it is full and
  // the output is stalled; written flat to avoid a combinational ready chain.
  always_comb begin
    ready_s = '0;
    full_s  = 1'b1;
    for (int s = 0; s < PIPE_STAGES; s++) begin
      full_s = 1'b1;
      for (int t = s; t < PIPE_STAGES; t++) begin
        full_s = full_s & v_q[t];
      end
      ready_s[s] = out_ready | ~full_s;
    end
  end

  assign in_ready = ready_s[0] & ~flush;
  assign accept_s = in_valid & in_ready;
  assign emit_s   = v_q[LAST] & out_ready;

  // Stage advance; flush clears valids but lets data registers go stale.
  always_comb begin
    v_d = v_q;
    m_d = m_q;
    d_d = d_q;
    if (ready_s[0]) begin
      v_d[0] = in_valid & ~flush;
      m_d[0] = mode_s;
      d_d[0] = sub_s;
    end else begin
      v_d[0] = v_q[0] & ~flush;
    end
    for (int s = 1; s < PIPE_STAGES; s++) begin
      if (ready_s[s]) begin
        v_d[s] = v_q[s-1] & ~flush;
        m_d[s] = m_q[s-1];
        d_d[s] = d_q[s-1];
      end else begin
        v_d[s] = v_q[s] & ~flush;
      end
    end
  end

  // Occupancy tracks popcount(v) incrementally.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = 3'd0;
    end else if (accept_s && !emit_s) begin
      occ_d = occ_q + 3'd1;
    end else if (emit_s && !accept_s) begin
      occ_d = occ_q - 3'd1;
    end else begin
      occ_d = occ_q;
    end
  end

  // Pipeline and counter state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      m_q   <= '0;
      d_q   <= '0;
      occ_q <= 3'd0;
    end else begin
      v_q   <= v_d;
      m_q   <= m_d;
      d_q   <= d_d;
      occ_q <= occ_d;
    end
  end

  assign out_valid = v_q[LAST];
  assign out_inv   = m_q[LAST];
  assign out_data  = d_q[LAST];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_aes_sbox_pipe.sv
// Directed bench for aes_sbox_pipe: hand vectors plus a streaming sweep checked
// against S-box tables computed here from GF(2^8) inversion and the affine map.
module tb_aes_sbox_pipe;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_inv, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid, out_inv;
  logic [31:0] out_data;
  logic [2:0]  occupancy;
  logic        fo_in_ready, fo_out_valid, fo_out_inv;
  logic [31:0] fo_out_data;
  logic [2:0]  fo_occupancy;

  int errors = 0;
  int checks = 0;
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];
  logic [7:0] eb;
  logic [7:0] gi;
  int j;

  always #5 clk = ~clk;

  aes_sbox_pipe #(.LANES(4), .PIPE_STAGES(2), .INV_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inv(in_inv), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_inv(out_inv), .out_data(out_data), .occupancy(occupancy)
  );

  aes_sbox_pipe #(.LANES(4), .PIPE_STAGES(2), .INV_EN(0)) dut_fwd (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(fo_in_ready),
    .in_inv(in_inv), .in_data(in_data), .out_valid(fo_out_valid), .out_ready(out_ready),
    .out_inv(fo_out_inv), .out_data(fo_out_data), .occupancy(fo_occupancy)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] x);
    logic [7:0] r = x;
    logic [7:0] acc = x;
    for (int i = 0; i < 4; i++) begin
      r   = {r[6:0], r[7]};
      acc = acc ^ r;
    end
    return acc ^ 8'h63;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_inv = 1'b0;
    in_data = 32'h0; out_ready = 1'b1;

    for (int x = 0; x < 256; x++) begin
      gi = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) gi = 8'(y);
      end
      fwd_tab[x] = affine(gi);
    end
    for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

    #2;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_inv", {31'd0, out_inv}, 32'd0);
    check("rst_occupancy", {29'd0, occupancy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    tick(); rst_n = 1'b1; tick();

    // forward, latency 2
    in_valid = 1'b1; in_data = 32'h5300FF01; in_inv = 1'b0; tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("fwd_occ_c1", {29'd0, occupancy}, 32'd1);
    check("fwd_valid_c1", {31'd0, out_valid}, 32'd0);
    tick(); @(negedge clk);
    check("fwd_valid_c2", {31'd0, out_valid}, 32'd1);
    check("fwd_data", out_data, 32'hED63167C);
    check("fwd_inv", {31'd0, out_inv}, 32'd0);
    check("fwd_occ_c2", {29'd0, occupancy}, 32'd1);
    tick(); @(negedge clk);
    check("fwd_drain_valid", {31'd0, out_valid}, 32'd0);
    check("fwd_drain_occ", {29'd0, occupancy}, 32'd0);

    // inverse, and forward-only build with same stimulus
    tick();
    in_valid = 1'b1; in_data = 32'hED63167C; in_inv = 1'b1; tick();
    in_valid = 1'b0; tick(); @(negedge clk);
    check("inv_valid", {31'd0, out_valid}, 32'd1);
    check("inv_data", out_data, 32'h5300FF01);
    check("inv_tag", {31'd0, out_inv}, 32'd1);
    check("fonly_valid", {31'd0, fo_out_valid}, 32'd1);
    check("fonly_data", fo_out_data, 32'h55FB4710);
    check("fonly_tag", {31'd0, fo_out_inv}, 32'd0);
    tick();

    // backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0; in_data = 32'h00000000;
    @(negedge clk);
    check("bp_rdy0", {31'd0, in_ready}, 32'd1);
    tick(); in_data = 32'h01010101; @(negedge clk);
    check("bp_rdy1", {31'd0, in_ready}, 32'd1);
    check("bp_occ1", {29'd0, occupancy}, 32'd1);
    tick(); in_data = 32'h02020202; @(negedge clk);
    check("bp_rdy_full", {31'd0, in_ready}, 32'd0);
    check("bp_occ_full", {29'd0, occupancy}, 32'd2);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_data", out_data, 32'h63636363);
    tick(); @(negedge clk);
    check("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
    check("bp_hold_data", out_data, 32'h63636363);
    check("bp_hold_occ", {29'd0, occupancy}, 32'd2);
    tick(); out_ready = 1'b1; @(negedge clk);
    check("bp_release_rdy", {31'd0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0; @(negedge clk);
    check("bp_out2", out_data, 32'h7C7C7C7C);
    check("bp_occ_both", {29'd0, occupancy}, 32'd2);
    tick(); @(negedge clk);
    check("bp_out3", out_data, 32'h77777777);
    check("bp_occ_dec", {29'd0, occupancy}, 32'd1);
    tick(); @(negedge clk);
    check("bp_empty_valid", {31'd0, out_valid}, 32'd0);
    check("bp_empty_occ", {29'd0, occupancy}, 32'd0);

    // streaming 0x00..0xFF with alternating mode
    tick();
    for (int k = 0; k < 258; k++) begin
      if (k < 256) begin
        in_valid = 1'b1; in_data = {4{8'(k)}}; in_inv = k[0];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (k < 256) check("st_in_ready", {31'd0, in_ready}, 32'd1);
      if (k >= 2) begin
        j  = k - 2;
        eb = j[0] ? inv_tab[j] : fwd_tab[j];
        check("st_valid", {31'd0, out_valid}, 32'd1);
        check("st_data", out_data, {4{eb}});
        check("st_inv", {31'd0, out_inv}, {31'd0, j[0]});
      end
      tick();
    end

    // flush
    out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0; in_data = 32'h53535353; tick();
    in_data = 32'h01010101; tick(); @(negedge clk);
    check("fl_occ_full", {29'd0, occupancy}, 32'd2);
    tick();
    flush = 1'b1; out_ready = 1'b1; in_data = 32'hAAAAAAAA; @(negedge clk);
    check("fl_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush = 1'b0; in_data = 32'h53535353; @(negedge clk);
    check("fl_valid_after", {31'd0, out_valid}, 32'd0);
    check("fl_occ_after", {29'd0, occupancy}, 32'd0);
    tick(); in_valid = 1'b0; @(negedge clk);
    check("fl_post_occ", {29'd0, occupancy}, 32'd1);
    check("fl_post_valid1", {31'd0, out_valid}, 32'd0);
    tick(); @(negedge clk);
    check("fl_post_valid2", {31'd0, out_valid}, 32'd1);
    check("fl_post_data", out_data, 32'hEDEDEDED);
    tick();

    // asynchronous reset mid-stream
    in_valid = 1'b1; in_data = 32'h53535353; tick(); tick();
    #1;
    check("ar_pre_valid", {31'd0, out_valid}, 32'd1);
    #1; rst_n = 1'b0; #1;
    check("ar_valid", {31'd0, out_valid}, 32'd0);
    check("ar_data", out_data, 32'h0);
    check("ar_occ", {29'd0, occupancy}, 32'd0);
    in_valid = 1'b0;
    tick(); rst_n = 1'b1;
    in_valid = 1'b1; in_data = 32'h00000053; in_inv = 1'b0; @(negedge clk);
    check("ar_in_ready", {31'd0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0; tick(); @(negedge clk);
    check("ar_first_valid", {31'd0, out_valid}, 32'd1);
    check("ar_first_data", out_data, 32'h636363ED);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
